mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have the following ports, listed as name, direction, width, meaning.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port if_req, input, 1 bit: fetch read request; held stable until if_done.
REQ-005 SHALL have port if_addr, input, 16 bits: fetch address.
REQ-006 SHALL have port if_flush, input, 1 bit: cancels the pending fetch (taken branch).
REQ-007 SHALL have port dm_rd / dm_wr, inputs, 1 bit each: data-memory read / write request; held until dm_done.
REQ-008 SHALL have port dm_addr / dm_wdata, inputs, 16 bits each: data address and write data.
REQ-009 SHALL have port mem_en / mem_wr, outputs, 1 bit each: one-cycle issue pulse to the shared memory; mem_wr=1 means write.
REQ-010 SHALL have port mem_addr / mem_wdata, outputs, 16 bits each: issued address and write data.
REQ-011 SHALL have port mem_rdata, input, 16 bits: memory read data, valid while mem_done=1.
REQ-012 SHALL have port mem_done, input, 1 bit: one-cycle completion pulse, at least 1 cycle after mem_en.
REQ-013 SHALL have port if_done / dm_done, outputs, 1 bit each: one-cycle completion pulses.
REQ-014 SHALL have port if_rdata / dm_rdata, outputs, 16 bits each: last completed read data, held until the next completion.
REQ-015 SHALL have port if_stall / dm_stall, outputs, 1 bit each: requester must freeze.
REQ-016 SHALL have port err, output, 1 bit: sticky protocol/timeout error.

Function
REQ-017 SHALL implement FSM states IDLE, IF_WAIT, DM_WAIT, IF_DROP.
REQ-018 In IDLE, with (dm_rd|dm_wr)=1, SHALL pulse mem_en with dm_addr/dm_wdata, set mem_wr=dm_wr, and go to DM_WAIT; data has priority over fetch.
REQ-019 In IDLE, with if_req=1, no data request and if_flush=0, SHALL pulse mem_en, mem_wr=0, with mem_addr=if_addr, and go to IF_WAIT.
REQ-020 In IF_WAIT/DM_WAIT, on mem_done, SHALL pulse the matching *_done, latch mem_rdata into *_rdata (reads only), and return to IDLE; the next issue occurs no earlier than the following cycle.
REQ-021 In IF_WAIT, with if_flush=1 and mem_done=0, SHALL go to IF_DROP; if if_flush and mem_done coincide, SHALL suppress if_done and go to IDLE.
REQ-022 In IF_DROP, on mem_done, SHALL go to IDLE with no if_done pulse and no if_rdata update.
REQ-023 SHALL drive if_stall = if_req & ~if_done; dm_stall = (dm_rd|dm_wr) & ~dm_done; both are combinational.
REQ-024 mem_addr/mem_wdata/mem_wr SHALL be registered at issue and held until the state leaves *_WAIT/IF_DROP.
REQ-025 SHALL keep a 4-bit wait counter, cleared at issue and incremented each cycle in a wait state; if it reaches 15 without mem_done, SHALL set err and return to IDLE.
REQ-026 err SHALL also be set by dm_rd&dm_wr, or by mem_done in IDLE; it is cleared only by rst.
REQ-027 After an error, SHALL continue arbitrating normally.

Reset
REQ-028 rst SHALL force state IDLE and clear the counter, err, *_rdata, mem_addr, mem_wdata and mem_wr; mem_en, *_done and stalls SHALL be 0 in the reset cycle.
REQ-029 rst mid-transaction SHALL abandon it silently; a late mem_done in IDLE after reset SHALL set err.

Structure
REQ-030 State encodings, TIMEOUT=15 and widths SHALL live in a shared localparam include file.
REQ-031 The wait counter SHALL be sub-module arb_timer (clear, enable, expired).

Verification
REQ-032 Fetch-only, addr 0x0010, mem_done 3 cycles after mem_en, rdata 0xBEEF -> if_done one pulse, if_rdata=0xBEEF, if_stall high for 3 cycles.
REQ-033 if_req and dm_wr rise the same cycle, addr 0x0100, wdata 0x1234 -> memory write issues first; fetch issues the cycle after dm_done.
REQ-034 Fetch issued, if_flush at cycle+1, mem_done at cycle+4 -> no if_done, if_rdata unchanged, state IDLE at cycle+5.
REQ-035 mem_done never arrives -> err=1 after 15 wait cycles, state IDLE, subsequent fetch completes normally, err stays 1.
REQ-036 rst asserted in DM_WAIT -> next cycle all outputs reset; stray mem_done -> err=1.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, timeout and FSM state encoding for the memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;

  // Number of wait cycles allowed before a transaction is abandoned.
  localparam logic [CNT_W-1:0] TIMEOUT = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IF_WAIT = 2'd1,
    ST_DM_WAIT = 2'd2,
    ST_IF_DROP = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_arb_timer.sv
// Wait-cycle counter for the arbiter. expired_o flags the enabled cycle
// whose increment brings the count up to TIMEOUT.
module arb_timer
  import mem_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear on issue, otherwise advance while a transaction waits.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = enable_i & (cnt_q == (TIMEOUT - CNT_ONE));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch + data) in front of one shared memory port.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no transaction outstanding; may issue data (first) or fetch
// ST_IF_WAIT | fetch issued, waiting for mem_done
// ST_DM_WAIT | data read/write issued, waiting for mem_done
// ST_IF_DROP | fetch cancelled by if_flush, waiting to swallow its mem_done
//
// Issue is combinational in ST_IDLE so a request is seen by memory in the
// same cycle; the issued address/data/direction are captured then and held
// for the rest of the transaction.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  input  logic              dm_rd,
  input  logic              dm_wr,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              if_done,
  output logic              dm_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              if_stall,
  output logic              dm_stall,
  output logic              err
);

  arb_state_t state_q, state_d;

  logic              issue_dm, issue_if;
  logic              if_done_c, dm_done_c;
  logic              stray_c, timeout_c;
  logic              in_wait, tmr_expired;

  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              err_q, err_d;

  assign in_wait = (state_q != ST_IDLE);

  arb_timer u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (mem_en),
    .enable_i  (in_wait),
    .expired_o (tmr_expired)
  );

  // Next state, issue decision and completion pulses; reset masks them all.
  always_comb begin
    state_d   = state_q;
    issue_dm  = 1'b0;
    issue_if  = 1'b0;
    if_done_c = 1'b0;
    dm_done_c = 1'b0;
    stray_c   = 1'b0;
    timeout_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        stray_c = mem_done;
        if (dm_rd || dm_wr) begin
          issue_dm = 1'b1;
          state_d  = ST_DM_WAIT;
        end else if (if_req && !if_flush) begin
          issue_if = 1'b1;
          state_d  = ST_IF_WAIT;
        end
      end
      ST_IF_WAIT: begin
        if (mem_done) begin
          if_done_c = ~if_flush;
          state_d   = ST_IDLE;
        end else if (tmr_expired) begin
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
        end else if (if_flush) begin
          state_d = ST_IF_DROP;
        end
      end
      ST_DM_WAIT: begin
        if (mem_done) begin
          dm_done_c = 1'b1;
          state_d   = ST_IDLE;
        end else if (tmr_expired) begin
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_IF_DROP: begin
        if (mem_done) begin
          state_d = ST_IDLE;
        end else if (tmr_expired) begin
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (rst) begin
      state_d   = ST_IDLE;
      issue_dm  = 1'b0;
      issue_if  = 1'b0;
      if_done_c = 1'b0;
      dm_done_c = 1'b0;
      stray_c   = 1'b0;
      timeout_c = 1'b0;
    end
  end

  // Datapath next values: capture at issue, latch read data at completion,
  // accumulate sticky error causes.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = mem_wr_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    err_d       = err_q;
    if (issue_dm) begin
      mem_addr_d  = dm_addr;
      mem_wdata_d = dm_wdata;
      mem_wr_d    = dm_wr;
    end else if (issue_if) begin
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
      mem_wr_d    = 1'b0;
    end
    if (if_done_c) begin
      if_rdata_d = mem_rdata;
    end
    if (dm_done_c && !mem_wr_q) begin
      dm_rdata_d = mem_rdata;
    end
    if ((dm_rd && dm_wr) || stray_c || timeout_c) begin
      err_d = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
    end
  end

  // The _d values equal the held registers except in the issue/completion
  // cycle, where they present the new address or read data immediately.
  assign mem_en    = issue_dm | issue_if;
  assign mem_addr  = mem_addr_d;
  assign mem_wdata = mem_wdata_d;
  assign mem_wr    = mem_wr_d;
  assign if_done   = if_done_c;
  assign dm_done   = dm_done_c;
  assign if_rdata  = if_rdata_d;
  assign dm_rdata  = dm_rdata_d;
  assign if_stall  = if_req & ~if_done_c & ~rst;
  assign dm_stall  = (dm_rd | dm_wr) & ~dm_done_c & ~rst;
  assign err       = err_q;

endmodule
